// File: rtl/zap_tlb_fill_ctrl.sv
// zap_tlb_fill_ctrl: TLB refill controller. On a miss it walks one section
// descriptor over a strobe/ack bus, validates it and writes {tag, descriptor}
// into the TLB tag RAM. Invalidate requests are ordered against in-flight
// walks so that no stale entry survives an invalidate.
module zap_tlb_fill_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned TAG_W = 12 - $clog2(DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_clken,
  input  logic                       i_miss,
  input  logic [31:0]                i_miss_va,
  input  logic [31:0]                i_ttbr,
  input  logic                       i_inv_req,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_fault,
  output logic                       o_wb_stb,
  output logic [31:0]                o_wb_adr,
  input  logic                       i_wb_ack,
  input  logic [31:0]                i_wb_dat,
  output logic                       o_wen,
  output logic [$clog2(DEPTH)-1:0]   o_waddr,
  output logic [TAG_W+32-1:0]        o_wdata,
  output logic                       o_inv
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DONE,
    S_INV
  } state_t;

  state_t      state;
  logic [11:0] va_hi;        // va[31:20]: section number of the walk in progress
  logic        pending_inv;  // invalidate seen while the walk read is outstanding
  logic        replay;       // INV was entered by aborting a walk; re-walk after it

  // Only the 16 KB-aligned part of the table base takes part in the address.
  logic [13:0] ttbr_lo_unused;
  assign ttbr_lo_unused = i_ttbr[13:0];

  // Walk FSM with registered outputs; everything holds while i_clken is low.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      va_hi       <= '0;
      pending_inv <= 1'b0;
      replay      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_fault     <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_adr    <= '0;
      o_wen       <= 1'b0;
      o_waddr     <= '0;
      o_wdata     <= '0;
      o_inv       <= 1'b0;
    end else if (i_clken) begin
      o_done  <= 1'b0;
      o_fault <= 1'b0;
      o_wen   <= 1'b0;
      o_inv   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_inv_req) begin
            // Invalidate wins; a concurrent miss is picked up when INV ends.
            state  <= S_INV;
            o_inv  <= 1'b1;
            o_busy <= 1'b1;
            replay <= 1'b0;
          end else if (i_miss) begin
            state    <= S_REQ;
            va_hi    <= i_miss_va[31:20];
            o_wb_stb <= 1'b1;
            o_wb_adr <= {i_ttbr[31:14], i_miss_va[31:20], 2'b00};
            o_busy   <= 1'b1;
          end
        end

        S_REQ: begin
          if (i_inv_req) begin
            pending_inv <= 1'b1;
          end
          if (i_wb_ack) begin
            o_wb_stb <= 1'b0;
            if (pending_inv || i_inv_req) begin
              // Descriptor may predate the invalidate: drop it and re-walk.
              state  <= S_INV;
              o_inv  <= 1'b1;
              replay <= 1'b1;
            end else if (i_wb_dat[1:0] == 2'b10) begin
              state   <= S_WRITE;
              o_wen   <= 1'b1;
              o_waddr <= va_hi[IDX_W-1:0];
              o_wdata <= {va_hi[11 -: TAG_W], i_wb_dat};
            end else begin
              state   <= S_DONE;
              o_done  <= 1'b1;
              o_fault <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          // An invalidate here lands after the write and clears it.
          state  <= S_DONE;
          o_done <= 1'b1;
          o_inv  <= i_inv_req;
        end

        S_DONE: begin
          if (i_inv_req) begin
            state  <= S_INV;
            o_inv  <= 1'b1;
            replay <= 1'b0;
          end else begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end

        S_INV: begin
          pending_inv <= 1'b0;
          replay      <= 1'b0;
          if (replay) begin
            state    <= S_REQ;
            o_wb_stb <= 1'b1;
            o_wb_adr <= {i_ttbr[31:14], va_hi, 2'b00};
          end else if (i_miss) begin
            state    <= S_REQ;
            va_hi    <= i_miss_va[31:20];
            o_wb_stb <= 1'b1;
            o_wb_adr <= {i_ttbr[31:14], i_miss_va[31:20], 2'b00};
          end else begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          o_busy   <= 1'b0;
          o_wb_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zap_tlb_fill_ctrl.sv
// Scoreboard bench for zap_tlb_fill_ctrl: stimulus pushes expected bus/RAM
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_zap_tlb_fill_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned TAG_W = 7;

  localparam logic [1:0] EV_ACK  = 2'd0;
  localparam logic [1:0] EV_WEN  = 2'd1;
  localparam logic [1:0] EV_INV  = 2'd2;
  localparam logic [1:0] EV_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] data;
  } ev_t;

  logic              i_clk;
  logic              i_reset_n;
  logic              i_clken;
  logic              i_miss;
  logic [31:0]       i_miss_va;
  logic [31:0]       i_ttbr;
  logic              i_inv_req;
  logic              o_busy;
  logic              o_done;
  logic              o_fault;
  logic              o_wb_stb;
  logic [31:0]       o_wb_adr;
  logic              i_wb_ack;
  logic [31:0]       i_wb_dat;
  logic              o_wen;
  logic [IDX_W-1:0]  o_waddr;
  logic [TAG_W+31:0] o_wdata;
  logic              o_inv;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Hand-computed values for va=0x0370_0000, ttbr=0x0000_4000:
  // adr = {0x00001, 0x037, 00} = 0x0000_40DC, index = 0x17, tag = 0x01.
  localparam logic [31:0] VA_A   = 32'h0370_0000;
  localparam logic [31:0] ADR_A  = 32'h0000_40DC;
  localparam logic [31:0] DAT_OK = 32'h0370_0C02;
  localparam logic [63:0] WEN_A  = 64'({5'h17, 7'h01, 32'h0370_0C02});
  // va=0x8010_0000 -> adr = 0x4000 + (0x801 << 2) = 0x0000_6004.
  localparam logic [31:0] VA_B   = 32'h8010_0000;
  localparam logic [31:0] ADR_B  = 32'h0000_6004;

  zap_tlb_fill_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clken   (i_clken),
    .i_miss    (i_miss),
    .i_miss_va (i_miss_va),
    .i_ttbr    (i_ttbr),
    .i_inv_req (i_inv_req),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_fault   (o_fault),
    .o_wb_stb  (o_wb_stb),
    .o_wb_adr  (o_wb_adr),
    .i_wb_ack  (i_wb_ack),
    .i_wb_dat  (i_wb_dat),
    .o_wen     (o_wen),
    .o_waddr   (o_waddr),
    .o_wdata   (o_wdata),
    .o_inv     (o_inv)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic push(input logic [1:0] kind, input logic [63:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [63:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%h, expected no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.data !== data) begin
        errors++;
        $display("FAIL event_order: got kind=%0d data=%h, expected kind=%0d data=%h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: an output counts once, on the cycle the DUT is enabled to consume it.
  always @(negedge i_clk) begin
    if (i_reset_n && i_clken) begin
      if (o_wb_stb && i_wb_ack) observe(EV_ACK, 64'(o_wb_adr));
      if (o_wen) begin
        observe(EV_WEN, 64'({o_waddr, o_wdata}));
        checks++;
        if (o_inv) begin
          errors++;
          $display("FAIL wen_inv_overlap: o_inv=%b with o_wen=1, required 0", o_inv);
        end
      end
      if (o_inv)  observe(EV_INV, 64'(0));
      if (o_done) observe(EV_DONE, 64'(o_fault));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // sel 0 waits for o_wb_stb, sel 1 for o_done; bounded.
  task automatic wait_high(input int sel, input string name);
    int n = 0;
    while (!((sel == 0) ? o_wb_stb : o_done) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, expected signal high", name, n);
    end
  endtask

  task automatic do_ack(input logic [31:0] dat);
    i_wb_ack = 1'b1;
    i_wb_dat = dat;
    tick();
    i_wb_ack = 1'b0;
    i_wb_dat = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset_n = 1'b0;
    i_clken   = 1'b1;
    i_miss    = 1'b0;
    i_miss_va = '0;
    i_ttbr    = 32'h0000_4000;
    i_inv_req = 1'b0;
    i_wb_ack  = 1'b0;
    i_wb_dat  = '0;
    repeat (2) tick();
    chk("reset_busy", 64'(o_busy), 64'(0));
    chk("reset_stb",  64'(o_wb_stb), 64'(0));
    chk("reset_outs", 64'({o_done, o_fault, o_wen, o_inv}), 64'(0));
    i_reset_n = 1'b1;
    tick();

    // Valid fill, cycle-exact latency.
    push(EV_ACK, 64'(ADR_A));
    push(EV_WEN, WEN_A);
    push(EV_DONE, 64'(0));
    i_miss_va = VA_A;
    i_miss    = 1'b1;
    tick();
    chk("fill_stb_t1", 64'(o_wb_stb), 64'(1));
    chk("fill_adr",    64'(o_wb_adr), 64'(ADR_A));
    do_ack(DAT_OK);
    chk("fill_wen_t2", 64'(o_wen), 64'(1));
    tick();
    chk("fill_done_t3", 64'({o_done, o_fault}), 64'(2'b10));
    i_miss = 1'b0;
    tick();
    chk("fill_idle_busy", 64'(o_busy), 64'(0));

    // Faulting descriptor: no write, done with fault.
    push(EV_ACK, 64'(ADR_B));
    push(EV_DONE, 64'(1));
    i_miss_va = VA_B;
    i_miss    = 1'b1;
    wait_high(0, "fault_stb");
    do_ack(32'h0000_0001);
    chk("fault_no_wen", 64'(o_wen), 64'(0));
    chk("fault_done",   64'({o_done, o_fault}), 64'(2'b11));
    i_miss = 1'b0;
    tick();

    // Invalidate mid-walk, ack three cycles later: discard, invalidate, re-walk.
    push(EV_ACK, 64'(ADR_A));
    push(EV_INV, 64'(0));
    push(EV_ACK, 64'(ADR_A));
    push(EV_WEN, WEN_A);
    push(EV_DONE, 64'(0));
    i_miss_va = VA_A;
    i_miss    = 1'b1;
    wait_high(0, "invmid_stb");
    i_inv_req = 1'b1;
    tick();
    i_inv_req = 1'b0;
    repeat (2) tick();
    do_ack(32'hDEAD_BEEE);
    chk("invmid_inv", 64'({o_inv, o_wb_stb, o_wen}), 64'(3'b100));
    tick();
    chk("invmid_restb", 64'(o_wb_stb), 64'(1));
    chk("invmid_readr", 64'(o_wb_adr), 64'(ADR_A));
    do_ack(DAT_OK);
    wait_high(1, "invmid_done");
    i_miss = 1'b0;
    tick();

    // Invalidate and miss together in IDLE: invalidate first, then walk.
    push(EV_INV, 64'(0));
    push(EV_ACK, 64'(ADR_A));
    push(EV_WEN, WEN_A);
    push(EV_DONE, 64'(0));
    i_miss_va = VA_A;
    i_miss    = 1'b1;
    i_inv_req = 1'b1;
    tick();
    i_inv_req = 1'b0;
    chk("both_inv_first", 64'({o_inv, o_wb_stb, o_busy}), 64'(3'b101));
    tick();
    chk("both_stb_next", 64'({o_inv, o_wb_stb}), 64'(2'b01));
    do_ack(DAT_OK);
    wait_high(1, "both_done");
    i_miss = 1'b0;
    tick();

    // Asynchronous reset while strobing.
    i_miss_va = VA_B;
    i_miss    = 1'b1;
    wait_high(0, "rst_stb");
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("rst_async_stb",  64'(o_wb_stb), 64'(0));
    chk("rst_async_outs", 64'({o_busy, o_wb_adr, o_done, o_wen, o_inv}), 64'(0));
    i_miss = 1'b0;
    tick();
    i_reset_n = 1'b1;
    tick();
    chk("rst_after_idle", 64'({o_busy, o_wb_stb}), 64'(0));

    // Clock enable low for four cycles while writing.
    push(EV_ACK, 64'(ADR_A));
    push(EV_WEN, WEN_A);
    push(EV_DONE, 64'(0));
    i_miss_va = VA_A;
    i_miss    = 1'b1;
    wait_high(0, "clken_stb");
    do_ack(DAT_OK);
    chk("clken_wen", 64'(o_wen), 64'(1));
    i_clken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clken_frozen", 64'({o_wen, o_done, o_busy}), 64'(3'b101));
    end
    i_clken = 1'b1;
    tick();
    chk("clken_done", 64'({o_wen, o_done}), 64'(2'b01));
    i_miss = 1'b0;
    tick();

    // Invalidate during WRITE: o_inv comes with o_done, after the write.
    push(EV_ACK, 64'(ADR_A));
    push(EV_WEN, WEN_A);
    push(EV_INV, 64'(0));
    push(EV_DONE, 64'(0));
    i_miss_va = VA_A;
    i_miss    = 1'b1;
    wait_high(0, "wrinv_stb");
    do_ack(DAT_OK);
    i_inv_req = 1'b1;
    tick();
    i_inv_req = 1'b0;
    chk("wrinv_done_inv", 64'({o_inv, o_done, o_wen}), 64'(3'b110));
    i_miss = 1'b0;
    tick();
    chk("wrinv_idle", 64'(o_busy), 64'(0));

    repeat (2) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
